// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the main-memory arbiter.
//   state_e     - arbiter FSM states
//   owner_e     - which fill FSM owns the current burst
//   BURST_WORDS - reads per cache-block fill
//   WORD_STRIDE - address step between consecutive burst reads
//   BLOCK_MASK  - clears the in-block offset to form the burst base
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StIssue,
    StDrain
  } state_e;

  typedef enum logic {
    OwnI,
    OwnD
  } owner_e;

  localparam int unsigned BURST_WORDS = 8;
  localparam int unsigned WORD_STRIDE = 2;
  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

endpackage

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: holds the block base of the current fill and counts issued reads.
//   clk_i       - system clock
//   rst_i       - asynchronous active-high reset
//   start_i     - capture base from miss_addr_i and clear the issue count
//   miss_addr_i - miss address of the winning fill FSM
//   step_i      - one read issued this cycle
//   addr_o      - address of the read to issue this cycle
//   last_o      - the read issued this cycle is the final one of the burst
module burst_addr_gen
  import mem_arb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] miss_addr_i,
  input  logic        step_i,
  output logic [15:0] addr_o,
  output logic        last_o
);

  logic [15:0] base_q;
  logic [3:0]  issue_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q      <= '0;
      issue_cnt_q <= '0;
    end else if (start_i) begin
      // Base offset is always zero, so a burst never leaves its block.
      base_q      <= miss_addr_i & BLOCK_MASK;
      issue_cnt_q <= '0;
    end else if (step_i) begin
      issue_cnt_q <= issue_cnt_q + 4'd1;
    end
  end

  assign addr_o = base_q + 16'(issue_cnt_q * WORD_STRIDE);
  assign last_o = (issue_cnt_q == 4'(BURST_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the pipelined main-memory port between the I-cache fill FSM,
// the D-cache fill FSM and D-cache write-through stores.
//   clk_i, rst_i               - clock, asynchronous active-high reset
//   icache_miss_i/addr_i       - I fill request level and miss address
//   dcache_miss_i/addr_i       - D fill request level and miss address
//   dcache_wr_i/_addr_i/_data_i - store request level, address, data
//   mem_en_o/_wr_o/_addr_o/_wdata_o - memory request port
//   mem_rdata_i/_valid_i       - in-order read returns
//   icache_data_o/_valid_o     - returned word and strobe to the I fill FSM
//   dcache_data_o/_valid_o     - returned word and strobe to the D fill FSM
//   dcache_wr_done_o           - one-cycle pulse when the store is issued
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        icache_miss_i,
  input  logic [15:0] icache_addr_i,
  input  logic        dcache_miss_i,
  input  logic [15:0] dcache_addr_i,
  input  logic        dcache_wr_i,
  input  logic [15:0] dcache_wr_addr_i,
  input  logic [15:0] dcache_wr_data_i,
  output logic        mem_en_o,
  output logic        mem_wr_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_rdata_valid_i,
  output logic [15:0] icache_data_o,
  output logic        icache_data_valid_o,
  output logic [15:0] dcache_data_o,
  output logic        dcache_data_valid_o,
  output logic        dcache_wr_done_o
);

  // Sized for the worst-case number of returns in flight, never below 4 bits.
  localparam int unsigned RetCntRaw = $clog2(MEM_LATENCY + BURST_WORDS + 1);
  localparam int unsigned RetCntW   = (RetCntRaw > 4) ? RetCntRaw : 4;

  state_e               state_q;
  owner_e               owner_q;
  logic [RetCntW-1:0]   ret_cnt_q;
  logic                 grant_fill;
  logic [15:0]          burst_addr;
  logic                 issue_last;
  logic                 in_burst;

  // A store always wins, so a fill is only granted when no store is pending.
  assign grant_fill = (state_q == StIdle) && !dcache_wr_i && (dcache_miss_i || icache_miss_i);

  burst_addr_gen u_burst_addr_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (grant_fill),
    .miss_addr_i (dcache_miss_i ? dcache_addr_i : icache_addr_i),
    .step_i      (state_q == StIssue),
    .addr_o      (burst_addr),
    .last_o      (issue_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      owner_q   <= OwnI;
      ret_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dcache_wr_i) begin
            state_q <= StWrite;
          end else if (dcache_miss_i) begin
            state_q   <= StIssue;
            owner_q   <= OwnD;
            ret_cnt_q <= '0;
          end else if (icache_miss_i) begin
            state_q   <= StIssue;
            owner_q   <= OwnI;
            ret_cnt_q <= '0;
          end
        end
        StWrite: state_q <= StIdle;
        StIssue: begin
          // Early returns can overlap the tail of the issue phase.
          if (mem_rdata_valid_i) ret_cnt_q <= ret_cnt_q + 1'b1;
          if (issue_last) state_q <= StDrain;
        end
        StDrain: begin
          if (mem_rdata_valid_i) begin
            ret_cnt_q <= ret_cnt_q + 1'b1;
            if (ret_cnt_q == RetCntW'(BURST_WORDS - 1)) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_en_o         = 1'b0;
    mem_wr_o         = 1'b0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;
    dcache_wr_done_o = 1'b0;
    unique case (state_q)
      StWrite: begin
        mem_en_o         = 1'b1;
        mem_wr_o         = 1'b1;
        mem_addr_o       = dcache_wr_addr_i;
        mem_wdata_o      = dcache_wr_data_i;
        dcache_wr_done_o = 1'b1;
      end
      StIssue: begin
        mem_en_o   = 1'b1;
        mem_addr_o = burst_addr;
      end
      default: ;
    endcase
  end

  // Strays outside a burst are dropped; a dropped miss mutes its strobes at once.
  assign in_burst            = (state_q == StIssue) || (state_q == StDrain);
  assign icache_data_o       = mem_rdata_i;
  assign dcache_data_o       = mem_rdata_i;
  assign icache_data_valid_o = mem_rdata_valid_i && in_burst && (owner_q == OwnI) &&
                               icache_miss_i;
  assign dcache_data_valid_o = mem_rdata_valid_i && in_burst && (owner_q == OwnD) &&
                               dcache_miss_i;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single pipelined main-memory port between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores. It sits directly downstream of both cache fill FSMs and upstream of the main memory.
- For a miss, it generates its own 8-word burst: block base, then +2 through +14, one read per cycle.
- It routes each returned word to the owning FSM as that FSM's data-valid strobe.
- Stores are issued as single-cycle writes between bursts.

## Interface
- MEM_LATENCY, 4: cycles from an accepted read to `mem_rdata_valid`. Used only to size the outstanding-return counter, minimum width 4 bits.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- icache_miss  in  1  I-cache fill FSM busy/miss level.
- icache_addr  in  16  I-cache miss address.
- dcache_miss  in  1  D-cache fill FSM busy/miss level.
- dcache_addr  in  16  D-cache miss address.
- dcache_wr  in  1  store request level; held until `dcache_wr_done`.
- dcache_wr_addr  in  16  store address.
- dcache_wr_data  in  16  store data.
- mem_en  out  1  memory request valid.
- mem_wr  out  1  1 = write, 0 = read; valid only with `mem_en`.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data from memory.
- mem_rdata_valid  in  1  read data valid; returns arrive in order.
- icache_data  out  16  equals `mem_rdata`.
- icache_data_valid  out  1  word strobe to the I fill FSM.
- dcache_data  out  16  equals `mem_rdata`.
- dcache_data_valid  out  1  word strobe to the D fill FSM.
- dcache_wr_done  out  1  one-cycle pulse when the store is issued.

## Operation
**States**
- IDLE: no memory requests are issued.
- WRITE: issues the pending store.
- ISSUE: issues the burst reads.
- DRAIN: waits for the remaining burst returns.

**Registers**
- `owner`: I or D.
- `base`: block base address, {addr[15:4], 4'b0}.
- `issue_cnt`: 0–8.
- `ret_cnt`: 0–8.

**IDLE priority (evaluated each cycle)**
1. `dcache_wr` → WRITE.
2. `dcache_miss` → ISSUE with owner = D.
3. `icache_miss` → ISSUE with owner = I.
- On entry to ISSUE, `base` is captured from the owner's address and both counters are cleared.

**WRITE (exactly one cycle)**
- Drives `mem_en`=1, `mem_wr`=1, `mem_addr`=`dcache_wr_addr`, `mem_wdata`=`dcache_wr_data`.
- Drives `dcache_wr_done`=1.
- Next state is IDLE.

**ISSUE**
- Each cycle drives `mem_en`=1, `mem_wr`=0, `mem_addr` = `base` + 2·`issue_cnt`, then increments `issue_cnt`.
- After the 8th issue, goes to DRAIN.
- Returns may begin arriving while still in ISSUE.

**DRAIN**
- Each `mem_rdata_valid` increments `ret_cnt`.
- When the 8th return arrives, goes to IDLE on the next edge.

**Return routing (combinational)**
- `dcache_data_valid` = `mem_rdata_valid` & owner==D & state ∈ {ISSUE, DRAIN} & `dcache_miss`.
- `icache_data_valid` is defined the same way for owner==I with `icache_miss`.

**Boundary conditions**
- **Miss dropped mid-burst:** the burst still completes and all 8 returns are counted. Valid strobes to the owner are suppressed from that cycle on.
- **Simultaneous miss and store:** the store goes first; the fill starts in the cycle after WRITE.
- **Request during a burst:** waits in its level input. The arbiter never preempts the owner.
- **Stray return:** a `mem_rdata_valid` seen in IDLE or WRITE (e.g. after a reset mid-burst) is ignored and never strobed.
- **Address arithmetic:** mod 2^16. `base`[3:0] is always 0, so a burst never crosses a block boundary.
- **Non-request outputs:** `mem_wr`, `mem_addr` and `mem_wdata` are 0 whenever `mem_en`=0.

## Timing
**Reset values**
- While `rst` is high: state IDLE, all counters and `owner` = 0.
- All outputs 0, except `icache_data`/`dcache_data`, which pass `mem_rdata` through.

**Read burst, request sampled in IDLE at edge t**
- Reads are issued in cycles t+1 through t+8.
- Returns arrive in cycles t+1+L through t+8+L, where L = MEM_LATENCY.
- The state returns to IDLE at edge t+9+L.
- The earliest next grant issues a request in cycle t+10+L.
- With L=4, total occupancy is 13 cycles.

**Store, `dcache_wr` sampled in IDLE at edge t**
- `mem_en` and `dcache_wr_done` are high in cycle t+1.
- IDLE resumes at edge t+2.

**Reset mid-operation**
- Takes effect immediately, without waiting for a clock edge.

## Structure
- A shared package `mem_arb_pkg` holds:
  - the state enum {IDLE, WRITE, ISSUE, DRAIN};
  - the owner enum {OWN_I, OWN_D};
  - `BURST_WORDS`=8 and `WORD_STRIDE`=2.
- One sub-module, `burst_addr_gen`: `base` register plus issue counter, outputting the burst address and a done flag.

## Test plan
- **D miss:** `dcache_miss`=1, `dcache_addr`=0x1236 → reads at 0x1230, 0x1232, …, 0x123E in 8 consecutive cycles; 8 `dcache_data_valid` strobes; `icache_data_valid` never asserted; back to IDLE at t+9+L.
- **Simultaneous misses:** I miss 0x0040 and D miss 0x8000 in the same cycle → D burst first; the I burst's first read (0x0040) comes one cycle after the D burst's IDLE cycle.
- **Store priority:** store to 0x00A0 with data 0xBEEF arriving together with an I miss → one write cycle, `mem_wr`=1 with 0x00A0/0xBEEF and `dcache_wr_done` pulse, then the I burst starts.
- **Miss dropped:** `icache_miss` deasserted after 3 returns → the remaining 5 returns produce no strobes, the burst still completes 8 returns, then IDLE.
- **Reset mid-burst:** `rst` asserted during ISSUE at `issue_cnt`=4 → `mem_en`=0 immediately; subsequent stray returns are not strobed; a new D miss after reset starts a clean burst at its base.
- **Wrap-around:** miss address 0xFFFE → reads 0xFFF0 through 0xFFFE, no overflow past 0xFFFE.
